// File: rtl/alu_issue.sv
// Issue/writeback stage around a combinational ALU: an in-order command FIFO
// feeds the ALU operands and the result is captured into a valid/ready output register.
module alu_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_cmd,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_op,
  input  logic [31:0]              alu_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  logic [3:0]       op_mem_q  [DEPTH];
  logic             err_mem_q [DEPTH];
  logic [31:0]      a_mem_q   [DEPTH];
  logic [31:0]      b_mem_q   [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [3:0] push_op;
  logic       push_err;
  logic       push;
  logic       pop;
  logic       empty;

  // Decode happens at push so the head entry drives the ALU without extra logic.
  always_comb begin
    push_op  = 4'b0000;
    push_err = 1'b0;
    case (in_cmd)
      3'd0:    push_op = 4'b0000;
      3'd1:    push_op = 4'b0010;
      3'd2:    push_op = 4'b0100;
      3'd3:    push_op = 4'b0101;
      3'd4:    push_op = 4'b0110;
      3'd5:    push_op = 4'b0111;
      3'd6:    push_op = 4'b1010;
      default: push_err = 1'b1;
    endcase
  end

  // in_ready depends on occupancy only; a full FIFO refuses even when a pop coincides.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid && in_ready;
  assign pop      = !empty && (!out_valid_q || out_ready);

  assign alu_a  = empty ? 32'd0   : a_mem_q[rd_ptr_q];
  assign alu_b  = empty ? 32'd0   : b_mem_q[rd_ptr_q];
  assign alu_op = empty ? 4'b0000 : op_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_err_d    = out_err_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      out_valid_d  = 1'b1;
      out_result_d = err_mem_q[rd_ptr_q] ? 32'd0 : alu_result;
      out_tag_d    = tag_mem_q[rd_ptr_q];
      out_err_d    = err_mem_q[rd_ptr_q];
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_err_q    <= out_err_d;
    end
  end

  // Entry storage needs no reset: occupancy gates everything read from it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        op_mem_q[gi]  <= push_op;
        err_mem_q[gi] <= push_err;
        a_mem_q[gi]   <= in_a;
        b_mem_q[gi]   <= in_b;
        tag_mem_q[gi] <= in_tag;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;
  assign out_err    = out_err_q;
  assign count      = count_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized phase,
// scored against a command-level reference queue.
module tb_alu_issue;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_cmd;
  logic [31:0]       in_a, in_b;
  logic [TAG_W-1:0]  in_tag;
  logic [31:0]       alu_a, alu_b;
  logic [3:0]        alu_op;
  logic [31:0]       alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_err;
  logic [$clog2(DEPTH):0] count;

  alu_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_err(out_err), .count(count)
  );

  always #5 clk = ~clk;

  // The ALU this stage drives; unknown opcodes return a marker value.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0100: alu_result = {31'd0, (alu_a != 0) && (alu_b != 0)};
      4'b0101: alu_result = {31'd0, (alu_a != 0) || (alu_b != 0)};
      4'b0110: alu_result = alu_a ^ alu_b;
      4'b0111: alu_result = ~(alu_a | alu_b);
      4'b1010: alu_result = {31'd0, alu_a > alu_b};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct {
    logic [31:0]      res;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   delivered   = 0;
  bit   toggle_rdy  = 0;

  function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [TAG_W-1:0] t);
    exp_t e;
    e.tag = t;
    e.err = (c == 3'd7);
    case (c)
      3'd0:    e.res = a + b;
      3'd1:    e.res = a - b;
      3'd2:    e.res = (a != 0 && b != 0) ? 32'd1 : 32'd0;
      3'd3:    e.res = (a != 0 || b != 0) ? 32'd1 : 32'd0;
      3'd4:    e.res = a ^ b;
      3'd5:    e.res = ~(a | b);
      3'd6:    e.res = (a > b) ? 32'd1 : 32'd0;
      default: e.res = 32'd0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // One clock: score any output handshake, record any accepted command, advance.
  task automatic tick();
    bit   acc, fire;
    exp_t e;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (fire) begin
      chk("out_expected", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
        chk("out_err", {31'd0, out_err}, {31'd0, e.err});
        delivered++;
      end
    end
    if (acc) q.push_back(model(in_cmd, in_a, in_b, in_tag));
    @(posedge clk);
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
  endtask

  task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t);
    bit done;
    in_valid = 1'b1; in_cmd = c; in_a = a; in_b = b; in_tag = t;
    done = 0;
    for (int n = 0; n < 50 && !done; n++) begin
      done = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("send_accept", {31'd0, done}, 32'd1);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() != 0; n++) tick();
    chk("drain_empty", q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    #3;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    #12 reset_n = 1'b1;
    tick();

    // ADD latency: pushed at edge N, valid after N+1
    send(3'd0, 32'd5, 32'd7, 4'd3);
    chk("add_not_yet", {31'd0, out_valid}, 32'd0);
    tick();
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_result", out_result, 32'd12);
    chk("add_tag", {28'd0, out_tag}, 32'd3);
    chk("add_err", {31'd0, out_err}, 32'd0);
    tick();

    // SUB then GTU back to back
    send(3'd1, 32'd3, 32'd5, 4'd1);
    send(3'd6, 32'hFFFF_FFFF, 32'd1, 4'd2);
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_result", out_result, 32'hFFFF_FFFE);
    tick();
    chk("gtu_valid", {31'd0, out_valid}, 32'd1);
    chk("gtu_result", out_result, 32'd1);
    tick();

    // Backpressure with a full FIFO
    out_ready = 1'b0;
    send(3'd4, 32'hF0, 32'h0F, 4'd1);
    send(3'd5, 32'd0, 32'd0, 4'd2);
    send(3'd2, 32'hF0, 32'd0, 4'd3);
    in_valid = 1'b1; in_cmd = 3'd3; in_a = 32'hF0; in_b = 32'd0; in_tag = 4'd4;
    #1;
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_tag", {28'd0, out_tag}, 32'd1);
    chk("bp_out_result", out_result, 32'hFF);
    tick(); tick();
    chk("bp_count_hold", {30'd0, count}, 32'd2);
    chk("bp_tag_stable", {28'd0, out_tag}, 32'd1);
    chk("bp_valid_stable", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    send(3'd3, 32'hF0, 32'd0, 4'd4);
    drain();

    // Illegal command, then a legal one
    send(3'd7, 32'd9, 32'd9, 4'd5);
    tick();
    chk("ill_err", {31'd0, out_err}, 32'd1);
    chk("ill_result", out_result, 32'd0);
    send(3'd0, 32'd1, 32'd1, 4'd6);
    tick();
    chk("post_ill_err", {31'd0, out_err}, 32'd0);
    chk("post_ill_result", out_result, 32'd2);
    drain();

    // Reset mid-operation
    out_ready = 1'b0;
    send(3'd0, 32'd1, 32'd2, 4'd7);
    send(3'd0, 32'd3, 32'd4, 4'd8);
    send(3'd0, 32'd5, 32'd6, 4'd9);
    chk("pre_rst_count", {30'd0, count}, 32'd2);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_count", {30'd0, count}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1 reset_n = 1'b1;
    q.delete();
    out_ready = 1'b1;
    base = delivered;
    repeat (5) tick();
    chk("post_rst_nothing", delivered - base, 32'd0);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    // Wrap-around stream with toggling out_ready
    base = delivered;
    toggle_rdy = 1;
    for (int i = 0; i < 10; i++) send(3'd0, i, i, TAG_W'(i));
    drain();
    toggle_rdy = 0;
    out_ready = 1'b1;
    chk("wrap_delivered", delivered - base, 32'd10);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_cmd    = 3'($urandom_range(0, 7));
      in_a      = ($urandom_range(0, 3) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? 32'd0 :
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      in_tag    = TAG_W'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    tick();
    chk("final_idle_count", {30'd0, count}, 32'd0);
    chk("final_idle_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
